// File: rtl/id_stage_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | id_stage_pipe : decode stage with register file, branch resolve, hazard    |
// |                 detection, ID/EX register and saturating stall counter     |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
module id_stage_pipe #(
  parameter int DATA_W = 32,
  parameter int AW     = 5,
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [AW-1:0]     rs_addr,
  input  logic [AW-1:0]     rt_addr,
  input  logic              use_rs,
  input  logic              use_rt,
  input  logic [AW-1:0]     dst_addr,
  input  logic [15:0]       imm16,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic              reg_we_in,
  input  logic              mem_read_in,
  input  logic [2:0]        br_mode,
  input  logic              m_we,
  input  logic              m_mem_read,
  input  logic [AW-1:0]     m_dst,
  input  logic [DATA_W-1:0] m_data,
  input  logic              w_we,
  input  logic [AW-1:0]     w_dst,
  input  logic [DATA_W-1:0] w_data,
  input  logic              hold,
  output logic              stall,
  output logic              branch_taken,
  output logic              flush_if,
  output logic              ex_valid,
  output logic              ex_we,
  output logic              ex_mem_read,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [AW-1:0]     ex_rs,
  output logic [AW-1:0]     ex_rt,
  output logic [AW-1:0]     ex_dst,
  output logic [15:0]       ex_imm,
  output logic [15:0]       stall_count
);

  localparam int c_numRegs = 2 ** AW;

  logic [DATA_W-1:0] r_regFile [c_numRegs];

  logic              r_exValid, r_exWe, r_exMemRead;
  logic [CTRL_W-1:0] r_exCtrl;
  logic [DATA_W-1:0] r_exRsData, r_exRtData;
  logic [AW-1:0]     r_exRs, r_exRt, r_exDst;
  logic [15:0]       r_exImm;
  logic [15:0]       r_stallCount;

  logic [DATA_W-1:0] w_rsRf, w_rtRf, w_rsOp, w_rtOp;
  logic              w_mAluFwd, w_isBranch, w_cond;
  logic              w_exHit, w_mHit, w_loadUse, w_brOnEx, w_brOnLoad, w_haz;

  // Entry 0 is never written; reads of address 0 are forced to zero below.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < c_numRegs; i++) r_regFile[i] <= '0;
    end else if (w_we && (w_dst != '0)) begin
      r_regFile[w_dst] <= w_data;
    end
  end

  assign w_rsRf = (rs_addr == '0) ? '0 :
                  (w_we && (w_dst == rs_addr)) ? w_data : r_regFile[rs_addr];
  assign w_rtRf = (rt_addr == '0) ? '0 :
                  (w_we && (w_dst == rt_addr)) ? w_data : r_regFile[rt_addr];

  // Only ALU results can be forwarded from M; a load there is still in flight.
  assign w_mAluFwd = m_we && !m_mem_read && (m_dst != '0);
  assign w_rsOp    = (w_mAluFwd && (m_dst == rs_addr)) ? m_data : w_rsRf;
  assign w_rtOp    = (w_mAluFwd && (m_dst == rt_addr)) ? m_data : w_rtRf;

  always_comb begin
    w_isBranch = 1'b1;
    w_cond     = 1'b0;
    case (br_mode)
      3'd1:    w_cond = (w_rsOp == w_rtOp);
      3'd2:    w_cond = (w_rsOp != w_rtOp);
      3'd3:    w_cond = w_rsOp[DATA_W-1] || (w_rsOp == '0);
      3'd4:    w_cond = !w_rsOp[DATA_W-1] && (w_rsOp != '0);
      3'd5:    w_cond = w_rsOp[DATA_W-1];
      3'd6:    w_cond = !w_rsOp[DATA_W-1];
      default: w_isBranch = 1'b0;
    endcase
  end

  assign w_exHit = (r_exDst != '0) &&
                   ((use_rs && (r_exDst == rs_addr)) || (use_rt && (r_exDst == rt_addr)));
  assign w_mHit  = (m_dst != '0) &&
                   ((use_rs && (m_dst == rs_addr)) || (use_rt && (m_dst == rt_addr)));

  assign w_loadUse  = r_exValid && r_exMemRead && w_exHit;
  assign w_brOnEx   = w_isBranch && r_exValid && r_exWe && w_exHit;
  assign w_brOnLoad = w_isBranch && m_we && m_mem_read && w_mHit;
  assign w_haz      = instr_valid && (w_loadUse || w_brOnEx || w_brOnLoad);

  assign stall        = w_haz || hold;
  assign branch_taken = instr_valid && w_cond && !stall;
  assign flush_if     = branch_taken;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_exValid   <= 1'b0;
      r_exWe      <= 1'b0;
      r_exMemRead <= 1'b0;
      r_exCtrl    <= '0;
      r_exRsData  <= '0;
      r_exRtData  <= '0;
      r_exRs      <= '0;
      r_exRt      <= '0;
      r_exDst     <= '0;
      r_exImm     <= '0;
    end else if (!hold) begin
      if (w_haz) begin
        r_exValid   <= 1'b0;
        r_exWe      <= 1'b0;
        r_exMemRead <= 1'b0;
        r_exCtrl    <= '0;
      end else begin
        r_exValid   <= instr_valid;
        r_exWe      <= instr_valid && reg_we_in;
        r_exMemRead <= instr_valid && mem_read_in;
        r_exCtrl    <= ctrl_in;
        r_exRsData  <= w_rsRf;
        r_exRtData  <= w_rtRf;
        r_exRs      <= rs_addr;
        r_exRt      <= rt_addr;
        r_exDst     <= dst_addr;
        r_exImm     <= imm16;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stallCount <= '0;
    end else if (w_haz && !hold && (r_stallCount != 16'hFFFF)) begin
      r_stallCount <= r_stallCount + 16'd1;
    end
  end

  assign ex_valid    = r_exValid;
  assign ex_we       = r_exWe;
  assign ex_mem_read = r_exMemRead;
  assign ex_ctrl     = r_exCtrl;
  assign ex_rs_data  = r_exRsData;
  assign ex_rt_data  = r_exRtData;
  assign ex_rs       = r_exRs;
  assign ex_rt       = r_exRt;
  assign ex_dst      = r_exDst;
  assign ex_imm      = r_exImm;
  assign stall_count = r_stallCount;

endmodule
`default_nettype wire

// File: tb/tb_id_stage_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_id_stage_pipe : directed stimulus with scoreboarded ID/EX transactions  |
// | Revision         : 1.0                                                     |
// +----------------------------------------------------------------------------+
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid, use_rs, use_rt, reg_we_in, mem_read_in;
  logic [4:0]  rs_addr, rt_addr, dst_addr, m_dst, w_dst;
  logic [15:0] imm16, ctrl_in;
  logic [2:0]  br_mode;
  logic        m_we, m_mem_read, w_we, hold;
  logic [31:0] m_data, w_data;
  logic        stall, branch_taken, flush_if, ex_valid, ex_we, ex_mem_read;
  logic [15:0] ex_ctrl, ex_imm, stall_count;
  logic [31:0] ex_rs_data, ex_rt_data;
  logic [4:0]  ex_rs, ex_rt, ex_dst;

  typedef struct {
    logic [31:0] rsd, rtd;
    logic [4:0]  rs, rt, dst;
    logic [15:0] imm, ctrl;
    logic        we, mr;
  } exp_t;

  exp_t sbq[$];
  int   nTests = 0;
  int   nFail  = 0;

  id_stage_pipe dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .use_rs(use_rs), .use_rt(use_rt),
    .dst_addr(dst_addr), .imm16(imm16), .ctrl_in(ctrl_in),
    .reg_we_in(reg_we_in), .mem_read_in(mem_read_in), .br_mode(br_mode),
    .m_we(m_we), .m_mem_read(m_mem_read), .m_dst(m_dst), .m_data(m_data),
    .w_we(w_we), .w_dst(w_dst), .w_data(w_data), .hold(hold),
    .stall(stall), .branch_taken(branch_taken), .flush_if(flush_if),
    .ex_valid(ex_valid), .ex_we(ex_we), .ex_mem_read(ex_mem_read),
    .ex_ctrl(ex_ctrl), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst), .ex_imm(ex_imm),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    instr_valid = 0; use_rs = 0; use_rt = 0; reg_we_in = 0; mem_read_in = 0;
    rs_addr = 0; rt_addr = 0; dst_addr = 0; imm16 = 0; ctrl_in = 0; br_mode = 0;
    m_we = 0; m_mem_read = 0; m_dst = 0; m_data = 0;
    w_we = 0; w_dst = 0; w_data = 0; hold = 0;
  endtask

  task automatic setId(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dst,
                       input logic urs, input logic urt, input logic we, input logic mr,
                       input logic [2:0] bm, input logic [15:0] imm, input logic [15:0] ctrl);
    instr_valid = 1; rs_addr = rs; rt_addr = rt; dst_addr = dst; use_rs = urs; use_rt = urt;
    reg_we_in = we; mem_read_in = mr; br_mode = bm; imm16 = imm; ctrl_in = ctrl;
  endtask

  task automatic push(input logic [31:0] rsd, input logic [31:0] rtd);
    exp_t e;
    e.rsd = rsd; e.rtd = rtd; e.rs = rs_addr; e.rt = rt_addr; e.dst = dst_addr;
    e.imm = imm16; e.ctrl = ctrl_in; e.we = reg_we_in; e.mr = mem_read_in;
    sbq.push_back(e);
  endtask

  task automatic wreg(input logic [4:0] a, input logic [31:0] d);
    idle();
    w_we = 1; w_dst = a; w_data = d;
    @(negedge clk);
    idle();
  endtask

  // Monitor: a freshly loaded valid ID/EX entry is any edge out of reset without hold.
  initial begin
    logic holdAtEdge, rstAtEdge;
    exp_t e;
    forever begin
      @(posedge clk);
      holdAtEdge = hold;
      rstAtEdge  = rst;
      #1;
      if (rstAtEdge && !holdAtEdge && ex_valid) begin
        if (sbq.size() == 0) begin
          chk("sb_unexpected_issue", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("sb_rs_data", ex_rs_data, e.rsd);
          chk("sb_rt_data", ex_rt_data, e.rtd);
          chk("sb_addrs", {17'd0, ex_rs, ex_rt, ex_dst}, {17'd0, e.rs, e.rt, e.dst});
          chk("sb_imm_ctrl", {ex_imm, ex_ctrl}, {e.imm, e.ctrl});
          chk("sb_we_mr", {30'd0, ex_we, ex_mem_read}, {30'd0, e.we, e.mr});
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct { logic [2:0] bm; logic [4:0] rs; logic exp; } br_t;
  br_t brTab[8] = '{
    '{3'd5, 5'd2, 1'b1}, '{3'd6, 5'd2, 1'b0}, '{3'd3, 5'd2, 1'b1}, '{3'd4, 5'd2, 1'b0},
    '{3'd7, 5'd2, 1'b0}, '{3'd3, 5'd0, 1'b1}, '{3'd4, 5'd0, 1'b0}, '{3'd6, 5'd0, 1'b1}
  };

  initial begin
    idle();
    rst = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ex_flags", {29'd0, ex_valid, ex_we, ex_mem_read}, 32'd0);
    chk("rst_ex_ctrl_imm", {ex_ctrl, ex_imm}, 32'd0);
    chk("rst_ex_data", ex_rs_data | ex_rt_data, 32'd0);
    chk("rst_ex_addrs", {17'd0, ex_rs, ex_rt, ex_dst}, 32'd0);
    chk("rst_stall_count", stall_count, 32'd0);
    chk("rst_comb_outs", {29'd0, stall, branch_taken, flush_if}, 32'd0);
    @(negedge clk);
    rst = 1;

    // Every register reads zero after reset.
    for (int i = 0; i < 16; i++) begin
      setId(5'(2 * i), 5'(2 * i + 1), 5'(i + 16), 1, 1, i[0], 0, 0, 16'(i * 16'h111), ~16'(i));
      push(0, 0);
      @(negedge clk);
    end

    // Write-first bypass, then a write to r0 is discarded.
    idle();
    w_we = 1; w_dst = 5; w_data = 32'h1234;
    setId(5, 0, 7, 1, 0, 1, 0, 0, 16'hBEEF, 16'hA5A5);
    push(32'h1234, 0);
    @(negedge clk);
    w_we = 1; w_dst = 0; w_data = 32'hDEAD;
    setId(0, 5, 0, 1, 1, 0, 0, 0, 16'h0001, 16'h0002);
    push(0, 32'h1234);
    @(negedge clk);

    // Load-use: one bubble, then issue.
    w_we = 1; w_dst = 3; w_data = 32'h33;
    setId(5, 0, 3, 1, 0, 1, 1, 0, 16'h0004, 16'h0001);
    push(32'h1234, 0);
    @(negedge clk);
    w_we = 0;
    setId(3, 5, 8, 1, 1, 1, 0, 0, 16'h0008, 16'h0010);
    #1;
    chk("lu_stall", stall, 1);
    @(negedge clk);
    #1;
    chk("lu_bubble_valid", ex_valid, 0);
    chk("lu_stall_count", stall_count, 1);
    chk("lu_stall_clear", stall, 0);
    push(32'h33, 32'h1234);
    @(negedge clk);

    // Branch with M forwarding; ID/EX data still comes from the register file.
    wreg(6, 32'd7);
    wreg(4, 32'h99);
    m_we = 1; m_dst = 4; m_data = 32'd7;
    setId(4, 6, 0, 1, 1, 0, 0, 3'd1, 16'h0020, 16'h0040);
    #1;
    chk("beq_fwd_taken", branch_taken, 1);
    chk("beq_fwd_flush", flush_if, 1);
    push(32'h99, 32'd7);
    @(negedge clk);
    setId(4, 6, 0, 1, 1, 0, 0, 3'd2, 16'h0021, 16'h0041);
    #1;
    chk("bne_fwd_taken", branch_taken, 0);
    push(32'h99, 32'd7);
    @(negedge clk);

    // Branch on an EX ALU result: one stall, then M forwarding resolves it.
    m_we = 0;
    setId(0, 0, 9, 0, 0, 1, 0, 0, 16'h0030, 16'h0003);
    push(0, 0);
    @(negedge clk);
    setId(9, 0, 0, 1, 1, 0, 0, 3'd2, 16'h0031, 16'h0005);
    #1;
    chk("brex_stall", stall, 1);
    chk("brex_not_taken_stalled", branch_taken, 0);
    @(negedge clk);
    m_we = 1; m_dst = 9; m_data = 32'h55;
    #1;
    chk("brex_stall_count", stall_count, 2);
    chk("brex_resolved_taken", branch_taken, 1);
    push(0, 0);
    @(negedge clk);

    // Signed single-operand compares and the reserved mode.
    wreg(2, 32'hFFFF_FFFF);
    foreach (brTab[k]) begin
      setId(brTab[k].rs, 0, 0, 1, 0, 0, 0, brTab[k].bm, 16'(k), 16'h0100);
      #1;
      chk($sformatf("signed_br_mode%0d_rs%0d", brTab[k].bm, brTab[k].rs), branch_taken, brTab[k].exp);
      push((brTab[k].rs == 5'd2) ? 32'hFFFF_FFFF : 32'd0, 0);
      @(negedge clk);
    end

    // Hold overrides a load-use hazard.
    idle();
    @(negedge clk);
    setId(0, 0, 10, 0, 0, 1, 1, 0, 16'h0010, 16'h0F0F);
    push(0, 0);
    @(negedge clk);
    hold = 1;
    setId(10, 0, 11, 1, 0, 1, 0, 0, 16'h0011, 16'h0F10);
    #1;
    chk("hold_stall", stall, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk("hold_frozen_dst", ex_dst, 10);
      chk("hold_frozen_mr", {30'd0, ex_valid, ex_mem_read}, 32'd3);
      chk("hold_count_same", stall_count, 2);
    end
    hold = 0;
    #1;
    chk("hold_release_stall", stall, 1);
    @(negedge clk);
    #1;
    chk("hold_release_bubble", ex_valid, 0);
    chk("hold_release_count", stall_count, 3);
    push(0, 0);
    @(negedge clk);

    // Saturation under a persistent branch-on-M-load hazard.
    idle();
    @(negedge clk);
    m_we = 1; m_mem_read = 1; m_dst = 3;
    setId(3, 0, 0, 1, 0, 0, 0, 3'd1, 16'h0, 16'h0);
    repeat (65540) @(negedge clk);
    #1;
    chk("sat_count", stall_count, 32'hFFFF);
    chk("sat_stall", stall, 1);
    @(negedge clk);
    #1;
    chk("sat_count_held", stall_count, 32'hFFFF);

    // Asynchronous reset in the middle of the stall.
    #2;
    rst = 0;
    #1;
    chk("async_rst_count", stall_count, 0);
    chk("async_rst_comb_stall", stall, 1);
    @(negedge clk);
    rst = 1;
    idle();
    setId(6, 2, 1, 1, 1, 0, 0, 0, 16'h0777, 16'h0888);
    push(0, 0);
    @(negedge clk);
    idle();
    #1;
    chk("post_rst_count", stall_count, 0);
    repeat (2) @(negedge clk);

    chk("sb_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_stage_pipe.md
# id_stage_pipe

Parametrised decode stage for the five-stage pipeline. It contains:
- a register file with a write-first bypass;
- branch-operand forwarding from M and W;
- a full branch comparator with six conditions;
- load-use and branch hazard detection with a stall output;
- the ID/EX pipeline register with bubble insertion and an external hold;
- a saturating stall counter.

It sits between the IF/ID register and EX, and takes its control bundle from the existing control unit.

## Interface
Parameters:
- DATA_W, 32, register and datapath width
- AW, 5, register address width; register file has 2^AW entries, entry 0 reads zero
- CTRL_W, 16, width of the opaque control bundle carried into EX

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low; clears every register, register-file entry and counter
- instr_valid  in  1  IF/ID holds a valid instruction
- rs_addr, rt_addr  in  AW  source register addresses
- use_rs, use_rt  in  1  instruction actually reads rs / rt
- dst_addr  in  AW  destination already selected by the regDst mux
- imm16  in  16  immediate field
- ctrl_in  in  CTRL_W  control bundle from the control unit
- reg_we_in, mem_read_in  in  1  instruction writes a register / is a load
- br_mode  in  3  0 none, 1 beq, 2 bne, 3 blez, 4 bgtz, 5 bltz, 6 bgez, 7 reserved (treated as none)
- m_we, m_mem_read  in  1  M-stage writes a register / is a load
- m_dst  in  AW  M-stage destination
- m_data  in  DATA_W  M-stage ALU result
- w_we  in  1  W-stage write enable
- w_dst  in  AW  W-stage destination
- w_data  in  DATA_W  W-stage write-back data
- hold  in  1  downstream freeze
- stall  out  1  freeze PC and IF/ID
- branch_taken  out  1  branch resolved taken this cycle
- flush_if  out  1  squash the instruction in IF
- ex_valid, ex_we, ex_mem_read  out  1  ID/EX fields
- ex_ctrl  out  CTRL_W  ID/EX control bundle
- ex_rs_data, ex_rt_data  out  DATA_W  ID/EX operand data
- ex_rs, ex_rt, ex_dst  out  AW  ID/EX register addresses
- ex_imm  out  16  ID/EX immediate
- stall_count  out  16  saturating count of hazard-stall cycles

## Operation
- **Register file**
  - Written at posedge when w_we=1 and w_dst!=0.
  - Reads are combinational.
  - A read of the address being written in the same cycle returns w_data (write-first).
  - Address 0 always reads 0.
- **Branch operand forwarding**, applied per source:
  - if m_we and !m_mem_read and m_dst!=0 and m_dst==src, use m_data;
  - otherwise use the register-file read, which covers W through the bypass.
  - ID/EX operand data uses the register-file read only; EX forwarding lives downstream.
- **Comparison** uses the forwarded operands:
  - eq/ne compare both operands;
  - lez/gtz/ltz/gez compare rs only, signed.
- **Hazard stall** (`haz`) requires instr_valid=1 and is asserted on any of:
  - (a) load-use: ex_valid and ex_mem_read and ex_dst!=0 and ((use_rs and ex_dst==rs_addr) or (use_rt and ex_dst==rt_addr));
  - (b) branch on EX result: br_mode in 1..6 and ex_valid and ex_we and ex_dst!=0 and matching a used source;
  - (c) branch on M load: br_mode in 1..6 and m_we and m_mem_read and m_dst!=0 and matching a used source.
- **Outputs**
  - stall = haz | hold.
  - branch_taken = instr_valid & condition true & !stall.
  - flush_if = branch_taken.
- **ID/EX register update at posedge**, in priority order:
  - hold=1: all ID/EX fields keep their values.
  - else haz=1: insert a bubble. ex_valid, ex_we and ex_mem_read go to 0 and ex_ctrl goes to 0; the other fields are don't-care.
  - else: load all fields from the inputs, with ex_valid=instr_valid. ex_we and ex_mem_read are gated by instr_valid.
- **stall_count** increments by 1 on each cycle with haz=1 and hold=0. It saturates at 0xFFFF.

## Timing
- Reset (rst=0, asynchronous) sets:
  - ex_valid=0, ex_we=0, ex_mem_read=0;
  - ex_ctrl=0, ex_rs_data=0, ex_rt_data=0;
  - ex_rs=0, ex_rt=0, ex_dst=0, ex_imm=0;
  - stall_count=0;
  - all register-file entries to 0.
- Reset is released synchronously to clk by the system.
- stall, branch_taken and flush_if are combinational. They are 0 while reset is asserted only when instr_valid=0.
- Latency: ID inputs appear on the ex_* outputs one cycle after the edge at which they are sampled.
- Branch resolves in the same cycle as decode, so there is one squashed IF slot.
- Load-use costs exactly 1 bubble.
- A branch depending on an EX ALU result costs 1 stall cycle, after which M forwarding supplies the value.
- A branch depending on an EX load costs 2 stall cycles.
- If reset asserts mid-stall, the block is in the post-reset state immediately and the counter restarts at 0.
- Simultaneous W write and ID read of the same register returns the new value the same cycle.

## Test plan
- Reset: with clk toggling, set rst=0 and then release it. All ex_* outputs and stall_count read 0, and every register reads 0.
- Write-first: set w_we=1, w_dst=5, w_data=0x1234 while rs_addr=5 with a valid ALU instruction. At the next edge ex_rs_data=0x1234. A write to w_dst=0 leaves reg 0 reading 0.
- Load-use: a load writing r3 enters EX, and ID reads r3 with use_rs=1. Expect stall=1 for one cycle with a bubble (ex_valid=0). The instruction issues the following cycle, and stall_count goes to 1.
- Branch forwarding: set m_we=1, m_dst=4, m_data=7, with reg 6 = 7 and beq r4,r6 in ID. Expect branch_taken=1 and flush_if=1. The same case with bne gives branch_taken=0.
- Signed compare: set r2=0xFFFFFFFF (-1). bltz gives taken=1, bgez gives 0, blez gives 1, bgtz gives 0.
- Hold priority: assert hold=1 during a load-use hazard for 3 cycles. The ex_* outputs stay frozen and stall_count is unchanged. Releasing hold gives 1 bubble, then issue. Also force 0xFFFF stalls and confirm stall_count holds at 0xFFFF.
